// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite encodings, controller state type and the byte-lane decode
// used by the AHB-Lite to BRAM bridge.
package ahb_bram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RAW_STALL = 3'd2,
    ERR1      = 3'd3,
    ERR2      = 3'd4
  } state_t;

  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

  // An all-zero mask marks a misaligned or oversized transfer.
  function automatic logic [3:0] byte_mask(input logic [1:0] addr_lo, input logic [2:0] size);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: if (!addr_lo[0]) mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: if (addr_lo == 2'b00) mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahblite_bram_fwd.sv
// Read-after-write forwarding: captures the write data phase that collides
// with a read and overlays those bytes on the BRAM word when it returns.
module ahblite_bram_fwd (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        capture,
  input  logic        hold,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_fwd
);

  logic        fwd_vld;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  // hold keeps the captured bytes alive across the extra cycle of a 2-cycle BRAM
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_vld  <= 1'b0;
      fwd_data <= '0;
      fwd_mask <= '0;
    end else if (capture) begin
      fwd_vld  <= 1'b1;
      fwd_data <= wdata;
      fwd_mask <= wmask;
    end else if (!hold) begin
      fwd_vld  <= 1'b0;
    end
  end

  always_comb begin
    rdata_fwd = rdata;
    if (fwd_vld) begin
      for (int b = 0; b < 4; b++) begin
        if (fwd_mask[b]) rdata_fwd[b*8 +: 8] = fwd_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ahblite_bram_ctrl.sv
// AHB-Lite slave bridging to a simple dual-port BRAM (1 or 2 cycle read latency).
// Define AHBLITE_BRAM_FWD_EN to forward colliding write bytes instead of stalling.
module ahblite_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic                  BRAM_RDEN,
  input  logic [31:0]           BRAM_RDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_idx, wr_idx, rd_idx;
  logic [3:0]            addr_mask, wr_mask;
  logic                  wr_pend;
  logic                  accept, illegal, wr_accept, rd_accept;
  logic                  hazard, stall_hazard;
  logic                  unused_bits;

  assign unused_bits = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};

  assign addr_idx  = HADDR[ADDR_WIDTH+1:2];
  assign addr_mask = byte_mask(HADDR[1:0], HSIZE);
  assign accept    = (state == IDLE) && HSEL && trans_active(HTRANS) && HREADY;
  assign illegal   = (addr_mask == 4'b0000);
  assign wr_accept = accept && !illegal && HWRITE;
  assign rd_accept = accept && !illegal && !HWRITE;
  // Read addressing the word whose write data is on the bus this very cycle
  assign hazard    = rd_accept && wr_pend && (addr_idx == wr_idx);

`ifdef AHBLITE_BRAM_FWD_EN
  assign stall_hazard = 1'b0;

  ahblite_bram_fwd u_fwd (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .capture   (hazard),
    .hold      (state == RD_WAIT),
    .wdata     (HWDATA),
    .wmask     (wr_mask),
    .rdata     (BRAM_RDATA),
    .rdata_fwd (HRDATA)
  );
`else
  assign stall_hazard = hazard;
  assign HRDATA       = BRAM_RDATA;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      wr_mask <= '0;
      rd_idx  <= '0;
    end else begin
      state   <= state_nxt;
      wr_pend <= wr_accept;
      if (wr_accept) begin
        wr_idx  <= addr_idx;
        wr_mask <= addr_mask;
      end
      if (rd_accept) rd_idx <= addr_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal)               state_nxt = ERR1;
          else if (!HWRITE) begin
            if (stall_hazard)        state_nxt = RAW_STALL;
            else if (RD_LATENCY == 2) state_nxt = RD_WAIT;
          end
        end
      end
      RAW_STALL: begin
        HREADYOUT = 1'b0;
        state_nxt = (RD_LATENCY == 2) ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        HREADYOUT = 1'b0;
        state_nxt = IDLE;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        HRESP     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAW_STALL re-reads the stalled address now that the write has landed
  assign BRAM_RDEN   = rd_accept || (state == RAW_STALL);
  assign BRAM_RDADDR = (state == RAW_STALL) ? rd_idx : addr_idx;

  assign BRAM_WRITE  = wr_pend ? wr_mask : 4'b0000;
  assign BRAM_WRADDR = wr_idx;
  assign BRAM_WDATA  = HWDATA;

endmodule
